// File: rtl/seq_sdiv_if.sv
// Operand/result bundle for the sequential signed divider: the ALU controller
// drives the master side, the divider implements the slave side.
interface seq_sdiv_if #(
  parameter int DW = 16
);
  logic [2*DW-1:0] x;
  logic [DW-1:0]   y;
  logic            start;
  logic [DW-1:0]   q;
  logic [DW-1:0]   r;
  logic            div_zero;
  logic            ovf;
  logic            busy;
  logic            done;

  modport master (
    output x, y, start,
    input  q, r, div_zero, ovf, busy, done
  );

  modport slave (
    input  x, y, start,
    output q, r, div_zero, ovf, busy, done
  );
endinterface

// File: rtl/seq_sdiv.sv
// Signed 2*DW / DW restoring divider, one quotient bit per cycle, with
// truncating quotient, dividend-signed remainder, divide-by-zero and overflow flags.
module seq_sdiv #(
  parameter int DW = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_sdiv_if.slave    bus
);
  localparam int CW = $clog2(2*DW);
  localparam logic [2*DW-1:0] Q_POS_LIM = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [2*DW-1:0] Q_NEG_LIM = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [DW-1:0]   rem_reg;
  logic [2*DW-1:0] quo_reg;
  logic [DW-1:0]   ym_reg;
  logic            qneg_reg;
  logic            rneg_reg;
  logic [DW-1:0]   q_reg;
  logic [DW-1:0]   r_reg;
  logic            div_zero_reg;
  logic            ovf_reg;
  logic            busy_reg;
  logic            done_reg;

  logic [2*DW-1:0] x_mag;
  logic [DW-1:0]   y_mag;
  logic [DW:0]     sh_rem;
  logic [DW+1:0]   trial;
  logic            borrow;
  logic [DW-1:0]   q_signed;
  logic [DW-1:0]   r_signed;
  logic            ovf_calc;

  assign x_mag  = bus.x[2*DW-1] ? -bus.x : bus.x;
  assign y_mag  = bus.y[DW-1]   ? -bus.y : bus.y;

  // The partial remainder is always below |y| between iterations, so DW bits
  // hold it; only the freshly shifted value needs the extra bit.
  assign sh_rem = {rem_reg, quo_reg[2*DW-1]};
  assign trial  = {1'b0, sh_rem} - {2'b0, ym_reg};
  assign borrow = trial[DW+1];

  // Low bits of a negation only depend on low bits of the operand.
  assign q_signed = qneg_reg ? -quo_reg[DW-1:0] : quo_reg[DW-1:0];
  assign r_signed = rneg_reg ? -rem_reg : rem_reg;
  assign ovf_calc = qneg_reg ? (quo_reg > Q_NEG_LIM) : (quo_reg > Q_POS_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      ym_reg       <= '0;
      qneg_reg     <= 1'b0;
      rneg_reg     <= 1'b0;
      q_reg        <= '0;
      r_reg        <= '0;
      div_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            qneg_reg <= bus.x[2*DW-1] ^ bus.y[DW-1];
            rneg_reg <= bus.x[2*DW-1];
            ym_reg   <= y_mag;
            rem_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
            // A zero divisor skips the loop; the raw dividend is parked in
            // quo_reg so its low half can be returned as the remainder.
            if (bus.y == '0) begin
              quo_reg   <= bus.x;
              state_reg <= FIX;
            end else begin
              quo_reg   <= x_mag;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg <= borrow ? sh_rem[DW-1:0] : trial[DW-1:0];
          quo_reg <= {quo_reg[2*DW-2:0], ~borrow};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(2*DW-1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
          if (ym_reg == '0) begin
            q_reg        <= '1;
            r_reg        <= quo_reg[DW-1:0];
            div_zero_reg <= 1'b1;
            ovf_reg      <= 1'b0;
          end else begin
            q_reg        <= q_signed;
            r_reg        <= r_signed;
            div_zero_reg <= 1'b0;
            ovf_reg      <= ovf_calc;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.q        = q_reg;
  assign bus.r        = r_reg;
  assign bus.div_zero = div_zero_reg;
  assign bus.ovf      = ovf_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
endmodule
